keycode_event_queue: RTL and testbench

KEYCODE_EVENT_QUEUE -- requirements
Module: keycode_event_queue

---
 rtl/kc_pkg.sv | 19 +
 rtl/kc_event_fifo.sv | 66 ++++++
 rtl/keycode_event_queue.sv | 212 +++++++++++++++++++++
 tb/tb_keycode_event_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/kc_pkg.sv
// Shared types and constants for the keycode event queue.
package kc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN_REL = 2'd1,
    SCAN_PRS = 2'd2,
    COMMIT   = 2'd3
  } kc_state_e;

  // HID ErrorRollOver keycode: the whole report is meaningless.
  localparam logic [7:0] ERR_ROLLOVER = 8'h01;

  // One extra pointer bit distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/kc_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO is accepted only
// when the head is popped in the same cycle, otherwise it is reported as dropped.
module kc_event_fifo
  import kc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              drop,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              empty_s, full_s, pop_s, wr_en_s;

  assign rd_valid = !empty_s;
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    empty_s = (wr_ptr_q == rd_ptr_q);
    full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s   = rd_ready && !empty_s;
    wr_en_s = push && (!full_s || pop_s);
    drop    = push && !wr_en_s;
    mem_d   = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns successive HID keycode reports into a queue of press/release events by
// diffing the new report against the last committed one, one slot per cycle.
module keycode_event_queue
  import kc_pkg::*;
#(
  parameter int NUM_SLOTS = 6,
  parameter int KEY_W     = 8,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SLOTS*KEY_W-1:0] keycode_in,
  input  logic                       report_strobe,
  output logic                       ev_valid,
  output logic [KEY_W-1:0]           ev_key,
  output logic                       ev_press,
  input  logic                       ev_ready,
  output logic                       busy,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic [7:0]                 drop_cnt
);

  localparam int SW = NUM_SLOTS * KEY_W;
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLOTS - 1);

  function automatic logic has_rollover(input logic [SW-1:0] snap);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit = hit | (snap[i*KEY_W +: KEY_W] == KEY_W'(ERR_ROLLOVER));
    end
    return hit;
  endfunction

  function automatic logic is_member(input logic [KEY_W-1:0] key, input logic [SW-1:0] snap);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit = hit | (snap[i*KEY_W +: KEY_W] == key);
    end
    return hit;
  endfunction

  // A repeated keycode only produces an event from its lowest slot.
  function automatic logic dup_below(input logic [SW-1:0] snap, input logic [IW-1:0] idx);
    logic             hit;
    logic [KEY_W-1:0] key;
    hit = 1'b0;
    key = snap[idx*KEY_W +: KEY_W];
    for (int j = 0; j < NUM_SLOTS; j++) begin
      hit = hit | ((j < int'(idx)) && (snap[j*KEY_W +: KEY_W] == key));
    end
    return hit;
  endfunction

  kc_state_e        state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    old_snap_q, old_snap_d;
  logic [SW-1:0]    new_snap_q, new_snap_d;
  logic [SW-1:0]    pend_snap_q, pend_snap_d;
  logic             pend_valid_q, pend_valid_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [KEY_W-1:0] old_key_s, new_key_s, push_key_s;
  logic             push_s, push_press_s, fifo_drop_s;
  logic [KEY_W:0]   fifo_rd_s;

  assign old_key_s = old_snap_q[idx_q*KEY_W +: KEY_W];
  assign new_key_s = new_snap_q[idx_q*KEY_W +: KEY_W];

  // start_q marks the cycle between latching a report and entering the scan.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    old_snap_d   = old_snap_q;
    new_snap_d   = new_snap_q;
    pend_snap_d  = pend_snap_q;
    pend_valid_d = pend_valid_q;
    start_d      = start_q;
    drop_cnt_d   = drop_cnt_q;
    push_s       = 1'b0;
    push_key_s   = '0;
    push_press_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = SCAN_REL;
          idx_d   = '0;
          start_d = 1'b0;
        end else if (pend_valid_q) begin
          pend_valid_d = 1'b0;
          start_d      = !has_rollover(pend_snap_q);
          new_snap_d   = start_d ? pend_snap_q : new_snap_q;
        end else if (report_strobe) begin
          start_d    = !has_rollover(keycode_in);
          new_snap_d = start_d ? keycode_in : new_snap_q;
        end else begin
          start_d = 1'b0;
        end
      end
      SCAN_REL: begin
        if ((old_key_s != '0) && !is_member(old_key_s, new_snap_q) &&
            !dup_below(old_snap_q, idx_q)) begin
          push_s     = 1'b1;
          push_key_s = old_key_s;
        end else begin
          push_s = 1'b0;
        end
        if (idx_q == LAST_IDX) begin
          state_d = SCAN_PRS;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SCAN_PRS: begin
        if ((new_key_s != '0) && !is_member(new_key_s, old_snap_q) &&
            !dup_below(new_snap_q, idx_q)) begin
          push_s       = 1'b1;
          push_key_s   = new_key_s;
          push_press_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      COMMIT: begin
        old_snap_d = new_snap_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Strobes that cannot start a scan now park in pending; only the newest survives.
    if (report_strobe && (busy_q || pend_valid_q)) begin
      pend_snap_d  = keycode_in;
      pend_valid_d = 1'b1;
      if (busy_q && pend_valid_q && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    busy_d = (state_d != IDLE) || start_d;
    if (fifo_drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      old_snap_q   <= '0;
      new_snap_q   <= '0;
      pend_snap_q  <= '0;
      pend_valid_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      old_snap_q   <= old_snap_d;
      new_snap_q   <= new_snap_d;
      pend_snap_q  <= pend_snap_d;
      pend_valid_q <= pend_valid_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  kc_event_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(KEY_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_data({push_press_s, push_key_s}),
    .drop     (fifo_drop_s),
    .rd_valid (ev_valid),
    .rd_data  (fifo_rd_s),
    .rd_ready (ev_ready)
  );

  assign ev_key   = fifo_rd_s[KEY_W-1:0];
  assign ev_press = fifo_rd_s[KEY_W];
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue with a 2-deep event FIFO.
module tb_keycode_event_queue;

  localparam int NS = 6;
  localparam int KW = 8;
  localparam int DP = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NS*KW-1:0] keycode_in = '0;
  logic            report_strobe = 1'b0;
  logic            ev_valid;
  logic [KW-1:0]   ev_key;
  logic            ev_press;
  logic            ev_ready = 1'b0;
  logic            busy;
  logic            overflow;
  logic            overflow_clr = 1'b0;
  logic [7:0]      drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;
  int v_at;

  keycode_event_queue #(
    .NUM_SLOTS(NS),
    .KEY_W    (KW),
    .DEPTH    (DP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .keycode_in   (keycode_in),
    .report_strobe(report_strobe),
    .ev_valid     (ev_valid),
    .ev_key       (ev_key),
    .ev_press     (ev_press),
    .ev_ready     (ev_ready),
    .busy         (busy),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NS*KW-1:0] mk(input logic [7:0] k0, k1, k2, k3, k4, k5);
    return {k5, k4, k3, k2, k1, k0};
  endfunction

  // Strobe one report, then watch 20 cycles counting busy and first ev_valid.
  task automatic send_report(input logic [NS*KW-1:0] keys, output int b_cnt, output int first_v);
    @(negedge clk);
    keycode_in    = keys;
    report_strobe = 1'b1;
    @(negedge clk);
    report_strobe = 1'b0;
    keycode_in    = '0;
    b_cnt   = 0;
    first_v = -1;
    for (int c = 0; c < 20; c++) begin
      if (ev_valid && (first_v < 0)) first_v = c;
      if (busy) b_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic expect_ev(input string tag, input logic [7:0] key, input logic press);
    check_val({tag, "_valid"}, ev_valid, 1);
    check_val({tag, "_key"}, ev_key, key);
    check_val({tag, "_press"}, ev_press, press);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_valid", ev_valid, 0);
    check_val("rst_key", ev_key, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // Single new key from an empty history: one press after the release pass.
    send_report(mk(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), busy_cnt, v_at);
    check_val("a_busy_cycles", busy_cnt, 14);
    check_val("a_valid_at", v_at, 8);
    expect_ev("a_ev0", 8'h04, 1'b1);
    check_val("a_empty", ev_valid, 0);

    send_report(mk(8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00), busy_cnt, v_at);
    check_val("b1_valid_at", v_at, 9);
    expect_ev("b1_ev0", 8'h05, 1'b1);
    check_val("b1_empty", ev_valid, 0);

    // Release of 0x04 is the first event, visible two cycles after the strobe.
    send_report(mk(8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00), busy_cnt, v_at);
    check_val("b2_valid_at", v_at, 2);
    expect_ev("b2_ev0", 8'h04, 1'b0);
    expect_ev("b2_ev1", 8'h06, 1'b1);
    check_val("b2_empty", ev_valid, 0);

    send_report(mk(8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00), busy_cnt, v_at);
    check_val("c_busy_cycles", busy_cnt, 0);
    check_val("c_no_events", ev_valid, 0);
    // Same report as the committed one must yield nothing if history survived.
    send_report(mk(8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00), busy_cnt, v_at);
    check_val("c2_busy_cycles", busy_cnt, 14);
    check_val("c2_no_events", ev_valid, 0);

    send_report('0, busy_cnt, v_at);
    expect_ev("d0_ev0", 8'h05, 1'b0);
    expect_ev("d0_ev1", 8'h06, 1'b0);
    check_val("d0_ovf", overflow, 0);
    send_report(mk(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 8'h00), busy_cnt, v_at);
    check_val("d_ovf_set", overflow, 1);
    expect_ev("d_ev0", 8'h0A, 1'b1);
    expect_ev("d_ev1", 8'h0B, 1'b1);
    check_val("d_empty", ev_valid, 0);
    check_val("d_ovf_sticky", overflow, 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check_val("d_ovf_clr", overflow, 0);

    // Three back-to-back strobes: middle one is superseded and never scanned.
    @(negedge clk);
    report_strobe = 1'b1;
    keycode_in    = mk(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h00);
    @(negedge clk);
    keycode_in    = mk(8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    keycode_in    = mk(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F);
    @(negedge clk);
    report_strobe = 1'b0;
    keycode_in    = '0;
    repeat (40) @(negedge clk);
    check_val("e_drop_cnt", drop_cnt, 1);
    check_val("e_busy", busy, 0);
    expect_ev("e_ev0", 8'h0E, 1'b1);
    expect_ev("e_ev1", 8'h0F, 1'b1);
    check_val("e_empty", ev_valid, 0);
    check_val("e_ovf", overflow, 0);

    // Reset in the second SCAN_PRS cycle with events queued and overflow set.
    @(negedge clk);
    report_strobe = 1'b1;
    keycode_in    = mk(8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    report_strobe = 1'b0;
    keycode_in    = '0;
    repeat (8) @(negedge clk);
    check_val("f_pre_valid", ev_valid, 1);
    check_val("f_pre_ovf", overflow, 1);
    check_val("f_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_val("f_rst_valid", ev_valid, 0);
    check_val("f_rst_key", ev_key, 0);
    check_val("f_rst_press", ev_press, 0);
    check_val("f_rst_busy", busy, 0);
    check_val("f_rst_ovf", overflow, 0);
    check_val("f_rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    send_report(mk(8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), busy_cnt, v_at);
    check_val("f_valid_at", v_at, 8);
    check_val("f_busy_cycles", busy_cnt, 14);
    expect_ev("f_ev0", 8'h07, 1'b1);
    check_val("f_empty", ev_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
